// File: rtl/sprite_pixel_renderer_if.sv
// Bus bundle for sprite_pixel_renderer.
//   master : video timing / sprite mover / ROM side (drives pixel stream,
//            sprite position and ROM read data; observes ROM address and
//            the final pixel stream).
//   slave  : the renderer itself.
// Handshake semantics: the pixel stream is valid-only. pix_valid qualifies
// hcount/vcount/bg_rgb in the same cycle, and rgb_valid qualifies rgb_out
// in the same cycle. There is no ready signal; every valid beat is
// accepted, and every accepted beat emerges exactly 3 cycles later.
// frame_start is a single-cycle strobe that is independent of pix_valid.
interface sprite_pixel_renderer_if #(
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 14
);
  logic               frame_start;
  logic               pix_valid;
  logic [9:0]         hcount;
  logic [9:0]         vcount;
  logic [COLOR_W-1:0] bg_rgb;
  logic [9:0]         x_coord;
  logic [9:0]         y_coord;
  logic [1:0]         direction;
  logic [ADDR_W-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [COLOR_W-1:0] rgb_out;
  logic               rgb_valid;

  modport master (
    output frame_start, pix_valid, hcount, vcount, bg_rgb,
           x_coord, y_coord, direction, rom_data,
    input  rom_addr, rgb_out, rgb_valid
  );

  modport slave (
    input  frame_start, pix_valid, hcount, vcount, bg_rgb,
           x_coord, y_coord, direction, rom_data,
    output rom_addr, rgb_out, rgb_valid
  );
endinterface

// File: rtl/sprite_pixel_renderer.sv
// Sprite pixel renderer.
// Snapshots the sprite position/direction once per frame, tests every
// scanned pixel against the sprite box, addresses the sprite ROM (one
// quadrant per direction) and merges the ROM colour over the background,
// treating the TRANSPARENT colour key as "show background".
// Ports:
//   clk   : pixel clock
//   reset : asynchronous, active-high
//   bus   : sprite_pixel_renderer_if.slave
//           in : frame_start, pix_valid, hcount, vcount, bg_rgb,
//                x_coord, y_coord, direction, rom_data
//           out: rom_addr (registered), rgb_out (registered), rgb_valid
// Pipeline: pixel in at cycle t -> rom_addr at t+1 -> rom_data valid
// during t+2 -> rgb_out/rgb_valid at t+3. One pixel per clock, no stall.
module sprite_pixel_renderer #(
  parameter int                 SIZE        = 64,
  parameter int                 X_MAX       = 640,
  parameter int                 Y_MAX       = 480,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  sprite_pixel_renderer_if.slave  bus
);

  localparam int CW     = $clog2(SIZE);
  localparam int ADDR_W = 2 + 2 * CW;

  // 11-bit constants so box ends and screen limits compare without wrap.
  localparam logic [10:0] SIZE_11  = 11'(SIZE);
  localparam logic [10:0] X_MAX_11 = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_11 = 11'(Y_MAX);

  // Frame latch: held for the whole frame so the sprite never tears.
  logic [9:0] x_l;
  logic [9:0] y_l;
  logic [1:0] dir_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_l   <= 10'd1;
      y_l   <= 10'd0;
      dir_l <= 2'b01;
    end else if (bus.frame_start) begin
      x_l   <= bus.x_coord;
      y_l   <= bus.y_coord;
      dir_l <= bus.direction;
    end
  end

  // Stage 0: hit test and address generation. A pixel that coincides with
  // frame_start still sees the old latch contents, because the latch only
  // updates on the edge that closes this cycle.
  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic [CW-1:0]     col_0;
  logic [CW-1:0]     row_0;
  logic              hit_0;
  logic [ADDR_W-1:0] addr_0;

  always_comb begin
    x_end  = {1'b0, x_l} + SIZE_11;
    y_end  = {1'b0, y_l} + SIZE_11;
    col_0  = CW'(bus.hcount - x_l);
    row_0  = CW'(bus.vcount - y_l);
    hit_0  = bus.pix_valid
             && (bus.hcount >= x_l) && ({1'b0, bus.hcount} < x_end)
             && (bus.vcount >= y_l) && ({1'b0, bus.vcount} < y_end)
             && ({1'b0, bus.hcount} < X_MAX_11)
             && ({1'b0, bus.vcount} < Y_MAX_11);
    addr_0 = {dir_l, row_0, col_0};
  end

  // Stages 1..3.
  logic               hit_1;
  logic               valid_1;
  logic [COLOR_W-1:0] bg_1;
  logic               hit_2;
  logic               valid_2;
  logic [COLOR_W-1:0] bg_2;
  logic [COLOR_W-1:0] rgb_next;

  // rom_data arrives during the cycle after rom_addr was registered, which
  // is exactly when hit_2/bg_2 hold that same pixel.
  always_comb begin
    rgb_next = '0;
    if (valid_2) begin
      if (hit_2 && (bus.rom_data != TRANSPARENT)) rgb_next = bus.rom_data;
      else                                        rgb_next = bg_2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rom_addr  <= '0;
      hit_1         <= 1'b0;
      valid_1       <= 1'b0;
      bg_1          <= '0;
      hit_2         <= 1'b0;
      valid_2       <= 1'b0;
      bg_2          <= '0;
      bus.rgb_out   <= '0;
      bus.rgb_valid <= 1'b0;
    end else begin
      bus.rom_addr  <= hit_0 ? addr_0 : '0;
      hit_1         <= hit_0;
      valid_1       <= bus.pix_valid;
      bg_1          <= bus.bg_rgb;
      hit_2         <= hit_1;
      valid_2       <= valid_1;
      bg_2          <= bg_1;
      bus.rgb_out   <= rgb_next;
      bus.rgb_valid <= valid_2;
    end
  end

endmodule
